i2c_target_regs: RTL and testbench

I2C target (responder) with a byte-wide register file, answering at a fixed 7-bit address. It is the far end of the HDMI transmitter configuration bus: it mirrors the transmitter's register map, including a live hot-plug-detect bit, so the I2C controller can be exercised on the board or in simulation without the transmitter fitted. It oversamples SCL/SDA on the system clock and drives SDA open-drain style.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_line_cond.sv | 62 ++++++
 rtl/i2c_target_regs.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_pkg : I2C target state encoding, R/W bit encoding and shared defaults
// Revision: 1.0
// ----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_IGNORE    = 4'd9
  } i2c_tgt_state;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [6:0]  I2C_TARGET_ADDR_DEFAULT = 7'h39;
  localparam logic [7:0]  I2C_HPD_REG_DEFAULT     = 8'h42;
  localparam int unsigned HPD_BIT                 = 6;

endpackage
`default_nettype wire

// File: rtl/i2c_line_cond.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_line_cond : synchronizer, optional 3-sample majority filter
//                 (I2C_TARGET_GLITCH_FILTER_EN) and edge detection for one line
// Revision: 1.0
// ----------------------------------------------------------------------------
module i2c_line_cond (
  input  logic clk,
  input  logic resetn,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_a;
  logic sync_b;
  logic level_prev;

  // Reset to the released (high) bus level so no edge is seen out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= line_in;
      sync_b <= sync_a;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist <= 2'b11;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], sync_b};
      filt <= (sync_b & hist[0]) | (sync_b & hist[1]) | (hist[0] & hist[1]);
    end
  end

  assign level = filt;
`else
  assign level = sync_b;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_prev <= 1'b1;
    end else begin
      level_prev <= level;
    end
  end

  assign rise = level & ~level_prev;
  assign fall = ~level & level_prev;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_target_regs : I2C target with a 256 x 8 register file and live HPD bit
// Revision: 1.0
// ----------------------------------------------------------------------------
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = I2C_TARGET_ADDR_DEFAULT,
  parameter logic [7:0] HPD_REG     = I2C_HPD_REG_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic       hpd_in,
  input  logic [7:0] host_addr,
  output logic [7:0] host_data,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_line_cond u_scl_cond (
    .clk     (clk),
    .resetn  (resetn),
    .line_in (scl_in),
    .level   (scl_s),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_cond u_sda_cond (
    .clk     (clk),
    .resetn  (resetn),
    .line_in (sda_in),
    .level   (sda_s),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  i2c_tgt_state state, state_nxt;

  logic [3:0] bit_cnt, cnt_nxt;
  logic [7:0] sreg, sreg_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic       mack, mack_nxt;
  logic       sda_nxt;
  logic       busy_nxt;
  logic       wr_en;

  logic [7:0] regs [256];
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic [7:0] store_byte;

  logic start_cond, stop_cond, bit_rise, bit_fall, byte_done, addr_match;

  // A bus condition coinciding with an SCL edge wins; the edge is dropped.
  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;
  assign bit_rise   = scl_rise & ~(start_cond | stop_cond);
  assign bit_fall   = scl_fall & ~(start_cond | stop_cond);
  assign byte_done  = (bit_cnt == 4'd8);
  assign addr_match = (sreg[7:1] == TARGET_ADDR);
  assign rx_byte    = {sreg[6:0], sda_s};

  always_comb begin
    rd_byte    = regs[ptr];
    store_byte = rx_byte;
    if (ptr == HPD_REG) begin
      rd_byte[HPD_BIT]    = hpd_in;
      store_byte[HPD_BIT] = 1'b0;
    end
  end

  assign host_data = regs[host_addr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start_cond) begin
      state_nxt = ST_ADDR;
    end else if (stop_cond) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR:      if (bit_fall && byte_done) state_nxt = addr_match ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:  if (bit_fall) state_nxt = (sreg[0] == RW_WRITE) ? ST_PTR : ST_RDATA;
        ST_PTR:       if (bit_fall && byte_done) state_nxt = ST_PTR_ACK;
        ST_PTR_ACK:   if (bit_fall) state_nxt = ST_WDATA;
        ST_WDATA:     if (bit_fall && byte_done) state_nxt = ST_WDATA_ACK;
        ST_WDATA_ACK: if (bit_fall) state_nxt = ST_WDATA;
        ST_RDATA:     if (bit_fall && byte_done) state_nxt = ST_RACK;
        ST_RACK:      if (bit_fall) state_nxt = mack ? ST_IGNORE : ST_RDATA;
        default:      state_nxt = state;
      endcase
    end
  end

  always_comb begin
    sda_nxt  = sda_out;
    busy_nxt = busy;
    cnt_nxt  = bit_cnt;
    sreg_nxt = sreg;
    ptr_nxt  = ptr;
    mack_nxt = mack;
    wr_en    = 1'b0;
    if (start_cond) begin
      cnt_nxt = 4'd0;
      sda_nxt = 1'b1;
    end else if (stop_cond) begin
      sda_nxt  = 1'b1;
      busy_nxt = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (bit_rise && !byte_done) begin
            sreg_nxt = rx_byte;
            cnt_nxt  = bit_cnt + 4'd1;
            if (state == ST_WDATA && bit_cnt == 4'd7) begin
              wr_en   = 1'b1;
              ptr_nxt = ptr + 8'd1;
            end
          end
          if (bit_fall && byte_done) begin
            cnt_nxt = 4'd0;
            if (state != ST_ADDR || addr_match) begin
              sda_nxt = 1'b0;
            end
            if (state == ST_ADDR && addr_match) begin
              busy_nxt = 1'b1;
            end
            if (state == ST_PTR) begin
              ptr_nxt = sreg;
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (bit_fall) begin
            sda_nxt = 1'b1;
            if (state == ST_ADDR_ACK && sreg[0] == RW_READ) begin
              sda_nxt  = rd_byte[7];
              sreg_nxt = {rd_byte[6:0], 1'b0};
            end
          end
        end
        ST_RDATA: begin
          if (bit_rise && !byte_done) begin
            cnt_nxt = bit_cnt + 4'd1;
          end
          if (bit_fall) begin
            if (byte_done) begin
              sda_nxt = 1'b1;
              ptr_nxt = ptr + 8'd1;
              cnt_nxt = 4'd0;
            end else begin
              sda_nxt  = sreg[7];
              sreg_nxt = {sreg[6:0], 1'b0};
            end
          end
        end
        ST_RACK: begin
          if (bit_rise) begin
            mack_nxt = sda_s;
          end
          if (bit_fall && !mack) begin
            sda_nxt  = rd_byte[7];
            sreg_nxt = {rd_byte[6:0], 1'b0};
          end
        end
        default: begin
          sda_nxt = 1'b1;
        end
      endcase
    end
  end

  // wr_data reports the byte as received; only the stored copy drops the HPD bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sda_out <= 1'b1;
      busy    <= 1'b0;
      bit_cnt <= 4'd0;
      sreg    <= 8'd0;
      ptr     <= 8'd0;
      mack    <= 1'b1;
      wr_stb  <= 1'b0;
      wr_addr <= 8'd0;
      wr_data <= 8'd0;
    end else begin
      sda_out <= sda_nxt;
      busy    <= busy_nxt;
      bit_cnt <= cnt_nxt;
      sreg    <= sreg_nxt;
      ptr     <= ptr_nxt;
      mack    <= mack_nxt;
      wr_stb  <= wr_en;
      if (wr_en) begin
        wr_addr <= ptr;
        wr_data <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) begin
        regs[i] <= 8'd0;
      end
    end else if (wr_en) begin
      regs[ptr] <= store_byte;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_i2c_target_regs : bus-level bench with register-map model and write
//                      scoreboard; glitch case under I2C_TARGET_GLITCH_FILTER_EN
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int         PH  = 8;
  localparam logic [6:0] TA  = I2C_TARGET_ADDR_DEFAULT;
  localparam logic [7:0] HPD = I2C_HPD_REG_DEFAULT;

  logic       clk       = 1'b0;
  logic       resetn    = 1'b0;
  logic       scl_drv   = 1'b1;
  logic       sda_drv   = 1'b1;
  logic       hpd_in    = 1'b0;
  logic [7:0] host_addr = 8'd0;
  logic       sda_out;
  logic [7:0] host_data;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       sda_line;

  assign sda_line = sda_drv & sda_out;

  i2c_target_regs dut (
    .clk       (clk),
    .resetn    (resetn),
    .scl_in    (scl_drv),
    .sda_in    (sda_line),
    .sda_out   (sda_out),
    .hpd_in    (hpd_in),
    .host_addr (host_addr),
    .host_data (host_data),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  ref_regs [256];
  logic [7:0]  ref_ptr;
  logic [15:0] exp_wr [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (resetn && wr_stb) begin
      if (exp_wr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wr_event: got addr %0h data %0h expected no strobe", wr_addr, wr_data);
      end else begin
        logic [15:0] e;
        e = exp_wr.pop_front();
        check("wr_event", 32'({wr_addr, wr_data}), 32'(e));
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_regs[i] = 8'd0;
    ref_ptr = 8'd0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    wait_clk(2);  sda_drv = 1'b1;
    wait_clk(PH - 2); scl_drv = 1'b1;
    wait_clk(PH); sda_drv = 1'b0;
    wait_clk(PH); scl_drv = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(2);  sda_drv = 1'b0;
    wait_clk(PH - 2); scl_drv = 1'b1;
    wait_clk(PH); sda_drv = 1'b1;
    wait_clk(PH);
  endtask

  task automatic send_bit(input logic b, input bit glitch, output logic s);
    wait_clk(2); sda_drv = b;
    wait_clk(PH - 2); scl_drv = 1'b1;
    if (glitch) begin
      wait_clk(2); scl_drv = 1'b0;
      wait_clk(1); scl_drv = 1'b1;
      wait_clk(PH / 2 - 3);
    end else begin
      wait_clk(PH / 2);
    end
    s = sda_line;
    wait_clk(PH / 2); scl_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], glitch, s);
    send_bit(1'b1, 1'b0, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, s);
      b[i] = s;
    end
    send_bit(nack, 1'b0, s);
  endtask

  task automatic do_write(input logic [7:0] p, input logic [7:0] data [$], input bit glitch);
    logic ack;
    bus_start();
    send_byte({TA, RW_WRITE}, glitch, ack);
    check("addr_ack", 32'(ack), 32'(0));
    check("busy_on_match", 32'(busy), 32'(1));
    send_byte(p, glitch, ack);
    check("ptr_ack", 32'(ack), 32'(0));
    ref_ptr = p;
    foreach (data[k]) begin
      exp_wr.push_back({ref_ptr, data[k]});
      ref_regs[ref_ptr] = (ref_ptr == HPD) ? (data[k] & 8'hBF) : data[k];
      ref_ptr++;
      send_byte(data[k], glitch, ack);
      check("data_ack", 32'(ack), 32'(0));
    end
    bus_stop();
    check("busy_after_stop", 32'(busy), 32'(0));
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] b;
    logic [7:0] e;
    bus_start();
    if (set_ptr) begin
      send_byte({TA, RW_WRITE}, 1'b0, ack);
      check("rd_setup_addr_ack", 32'(ack), 32'(0));
      send_byte(p, 1'b0, ack);
      check("rd_setup_ptr_ack", 32'(ack), 32'(0));
      ref_ptr = p;
      bus_start();
    end
    send_byte({TA, RW_READ}, 1'b0, ack);
    check("rd_addr_ack", 32'(ack), 32'(0));
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, b);
      e = ref_regs[ref_ptr];
      if (ref_ptr == HPD) e[6] = hpd_in;
      check("rd_data", 32'(b), 32'(e));
      ref_ptr++;
    end
    bus_stop();
    check("busy_after_read_stop", 32'(busy), 32'(0));
  endtask

  task automatic do_wrong(input logic [6:0] a, input logic rw);
    logic ack;
    bus_start();
    send_byte({a, rw}, 1'b0, ack);
    check("wrong_addr_nack", 32'(ack), 32'(1));
    check("wrong_addr_busy", 32'(busy), 32'(0));
    send_byte(8'($urandom), 1'b0, ack);
    check("ignored_byte_nack", 32'(ack), 32'(1));
    bus_stop();
  endtask

  task automatic host_check(input logic [7:0] a);
    host_addr = a;
    wait_clk(1);
    check("host_data", 32'(host_data), 32'(ref_regs[a]));
  endtask

  task automatic reset_midread();
    logic       ack;
    logic       s;
    bit         seen;
    logic [7:0] q [$];
    q = {8'hF0};
    do_write(8'h10, q, 1'b0);
    bus_start();
    send_byte({TA, RW_WRITE}, 1'b0, ack);
    send_byte(8'h10, 1'b0, ack);
    bus_start();
    send_byte({TA, RW_READ}, 1'b0, ack);
    check("rst_rd_addr_ack", 32'(ack), 32'(0));
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, s);
    seen = 1'b0;
    for (int c = 0; c < 2 * PH && !seen; c++) begin
      @(negedge clk);
      if (sda_out == 1'b0) seen = 1'b1;
    end
    check("bit3_driven_low", 32'(seen), 32'(1));
    resetn = 1'b0;
    #1;
    check("sda_async_release", 32'(sda_out), 32'(1));
    wait_clk(3);
    resetn = 1'b1;
    model_reset();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_wr_addr", 32'(wr_addr), 32'(0));
    check("rst_wr_data", 32'(wr_data), 32'(0));
    host_check(8'h10);
    bus_stop();
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] q [$];
    logic [6:0] wa;
    model_reset();
    wait_clk(5);
    check("reset_sda_out", 32'(sda_out), 32'(1));
    check("reset_wr_stb", 32'(wr_stb), 32'(0));
    check("reset_wr_addr", 32'(wr_addr), 32'(0));
    check("reset_wr_data", 32'(wr_data), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    resetn = 1'b1;
    wait_clk(5);
    host_check(8'h00);

    q = {8'h03};
    do_write(8'h98, q, 1'b0);
    host_check(8'h98);

    hpd_in = 1'b1;
    do_read(1'b1, HPD, 1);
    hpd_in = 1'b0;

    do_wrong(7'h3A, RW_WRITE);
    host_check(8'h98);
    host_check(8'h3A);

    q = {8'h11, 8'h22};
    do_write(8'hFF, q, 1'b0);
    host_check(8'hFF);
    host_check(8'h00);
    do_read(1'b0, 8'h00, 1);

    reset_midread();
    q = {8'hA5};
    do_write(8'h05, q, 1'b0);
    do_read(1'b1, 8'h05, 1);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    q = {8'h5A, 8'hC3};
    do_write(8'h20, q, 1'b1);
    host_check(8'h20);
    host_check(8'h21);
`endif

    for (int it = 0; it < 24; it++) begin
      hpd_in = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1: begin
          q = {};
          for (int k = 0; k < int'($urandom_range(1, 4)); k++) q.push_back(8'($urandom));
          do_write(8'($urandom_range(8'h38, 8'h48)), q, 1'b0);
        end
        2: do_read(1'($urandom_range(0, 1)), 8'($urandom_range(8'h38, 8'h48)), int'($urandom_range(1, 4)));
        default: begin
          wa = 7'($urandom);
          if (wa == TA) wa = wa ^ 7'h01;
          do_wrong(wa, 1'($urandom_range(0, 1)));
        end
      endcase
      host_check(ref_ptr - 8'd1);
      host_check(8'($urandom_range(8'h38, 8'h48)));
    end

    wait_clk(4);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
